// File: rtl/uart_sched_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int ERR_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = (req0 & req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two byte requesters onto one UART tx core, with start timeout detection.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [DATA_W-1:0]    data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [DATA_W-1:0]    data1,
    output logic                 ack1,
    output logic                 ld_tx_data,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_enable,
    input  logic                 tx_empty,
    output logic                 busy,
    output logic                 last_grant,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

    sched_state_t          state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  ld_nxt, en_nxt, ack0_nxt, ack1_nxt, err_nxt, last_nxt;
    logic [ERR_CNT_W-1:0]  err_cnt_nxt;
    logic [DATA_W-1:0]     tx_data_nxt;
    logic                  grant_valid, grant_idx;

    rr_arb2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign busy = (state != IDLE);

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ld_nxt      = 1'b0;
        en_nxt      = tx_enable;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;
        tx_data_nxt = tx_data;
        last_nxt    = last_grant;

        case (state)
            IDLE: begin
                en_nxt = 1'b0;
                if (tx_empty && grant_valid) begin
                    state_nxt   = LOAD;
                    tx_data_nxt = grant_idx ? data1 : data0;
                    last_nxt    = grant_idx;
                    ld_nxt      = 1'b1;
                    en_nxt      = 1'b1;
                    ack0_nxt    = ~grant_idx;
                    ack1_nxt    = grant_idx;
                end
            end
            LOAD: begin
                state_nxt = WAIT_START;
                cnt_nxt   = '0;
                en_nxt    = 1'b1;
            end
            WAIT_START: begin
                en_nxt = 1'b1;
                if (!tx_empty) begin
                    state_nxt = WAIT_DONE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Core never picked up the byte: give up and flag it.
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    en_nxt      = 1'b0;
                    err_nxt     = 1'b1;
                    err_cnt_nxt = sat_inc(err_cnt);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                en_nxt = 1'b1;
                if (tx_empty) begin
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_tx_data <= 1'b0;
            tx_enable  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            tx_data    <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ld_tx_data <= ld_nxt;
            tx_enable  <= en_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            err        <= err_nxt;
            err_cnt    <= err_cnt_nxt;
            tx_data    <= tx_data_nxt;
            last_grant <= last_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transaction-level reference model, directed cases and random traffic.
module tb_uart_tx_scheduler;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [DATA_W-1:0] data0, data1;
    logic              ack0, ack1, ld_tx_data, tx_enable, tx_empty, busy, last_grant, err;
    logic [DATA_W-1:0] tx_data;
    logic [7:0]        err_cnt;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    always #5 CLK = ~CLK;

    uart_tx_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .req0       (req0),
        .data0      (data0),
        .ack0       (ack0),
        .req1       (req1),
        .data1      (data1),
        .ack1       (ack1),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_empty   (tx_empty),
        .busy       (busy),
        .last_grant (last_grant),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Simple tx core: after a load it stays empty core_drop cycles, then busy core_len cycles.
    logic core_empty = 1'b1;
    bit   core_run = 0, core_rand = 0, core_stuck = 0, core_busy = 0;
    int   core_t = 0, core_drop = 2, core_len = 10;

    assign tx_empty = core_busy ? 1'b0 : (core_stuck ? 1'b1 : core_empty);

    always @(negedge CLK) begin
        if (ld_tx_data === 1'b1) begin
            core_run = 1;
            core_t   = 0;
            if (core_rand) begin
                core_drop = $urandom_range(0, 18);
                core_len  = $urandom_range(1, 12);
            end
        end else if (core_run) begin
            core_t++;
            core_empty = !(core_t > core_drop && core_t <= core_drop + core_len);
            if (core_t > core_drop + core_len) core_run = 0;
        end
    end

    // Reference model: a transfer is "active" from grant until the core finishes or start times out.
    bit              m_active = 0, m_load = 0, m_started = 0;
    int              m_wait = 0;
    logic            e_ld = 0, e_en = 0, e_ack0 = 0, e_ack1 = 0, e_err = 0, e_last = 1;
    int              e_err_cnt = 0;
    logic [DATA_W-1:0] e_tx_data = '0;

    always @(posedge CLK) begin
        logic w;
        e_ack0 = 0;
        e_ack1 = 0;
        e_err  = 0;
        if (reset) begin
            m_active = 0; m_load = 0; m_started = 0; m_wait = 0;
            e_err_cnt = 0; e_tx_data = '0; e_last = 1;
        end else if (!m_active) begin
            if (tx_empty && (req0 || req1)) begin
                w         = (req0 && req1) ? !e_last : req1;
                e_tx_data = w ? data1 : data0;
                e_last    = w;
                e_ack0    = !w;
                e_ack1    = w;
                m_active  = 1;
                m_load    = 1;
            end
        end else if (m_load) begin
            m_load = 0; m_started = 0; m_wait = 0;
        end else if (!m_started) begin
            if (!tx_empty) m_started = 1;
            else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    e_err     = 1;
                    e_err_cnt = (e_err_cnt >= 255) ? 255 : e_err_cnt + 1;
                    m_active  = 0;
                end
            end
        end else if (tx_empty) begin
            m_active = 0;
        end
        e_ld = m_load;
        e_en = m_active;
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("m_busy", busy, m_active);
            check("m_ld", ld_tx_data, e_ld);
            check("m_en", tx_enable, e_en);
            check("m_ack0", ack0, e_ack0);
            check("m_ack1", ack1, e_ack1);
            check("m_err", err, e_err);
            check("m_err_cnt", err_cnt, e_err_cnt);
            check("m_tx_data", tx_data, e_tx_data);
            check("m_last", last_grant, e_last);
        end
    end

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge CLK);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_ack(input string name, input int max);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(ack0 === 1'b1 || ack1 === 1'b1) && n < max);
        check(name, ack0 | ack1, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ld"}, ld_tx_data, 0);
        check({tag, "_en"}, tx_enable, 0);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_last"}, last_grant, 1);
    endtask

    initial begin
        logic [DATA_W-1:0] sent [3];
        int                nsent, k;
        bit                found;

        reset = 1; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        repeat (3) @(negedge CLK);
        check_reset_vals("rst");
        cmp_en = 1;
        reset  = 0;
        @(negedge CLK);

        // Single request, normal core handshake.
        req0 = 1; data0 = 8'h55;
        @(negedge CLK);
        check("d1_ack0", ack0, 1);
        check("d1_ld", ld_tx_data, 1);
        check("d1_tx_data", tx_data, 8'h55);
        req0 = 0; data0 = 8'hEE;
        wait_idle("d1_done", 40);
        check("d1_hold", tx_data, 8'h55);
        check("d1_last", last_grant, 0);

        // Both requesting from reset: strict alternation starting with requester 0.
        reset = 1; req0 = 1; req1 = 1; data0 = 8'hA1; data1 = 8'hB2;
        @(negedge CLK);
        reset = 0;
        nsent = 0; k = 0;
        while (nsent < 3 && k < 150) begin
            @(negedge CLK);
            k++;
            if (ld_tx_data === 1'b1) begin
                sent[nsent] = tx_data;
                nsent++;
            end
        end
        check("rr_count", nsent, 3);
        check("rr_0", sent[0], 8'hA1);
        check("rr_1", sent[1], 8'hB2);
        check("rr_2", sent[2], 8'hA1);
        req0 = 0; req1 = 0;
        wait_idle("rr_idle", 40);

        // Core never leaves empty: timeout after exactly TIMEOUT cycles in WAIT_START.
        reset = 1;
        @(negedge CLK);
        reset = 0; core_stuck = 1;
        req1 = 1; data1 = 8'h3C;
        @(negedge CLK);
        check("to_ack1", ack1, 1);
        req1 = 0;
        k = 0; found = 0;
        while (!found && k < 40) begin
            @(negedge CLK);
            k++;
            if (err === 1'b1) found = 1;
        end
        check("to_latency", k, TIMEOUT + 1);
        check("to_cnt", err_cnt, 1);
        @(negedge CLK);
        check("to_pulse", err, 0);
        repeat (20) @(negedge CLK);
        check("to_noretry", busy, 0);
        check("to_cnt_hold", err_cnt, 1);
        core_stuck = 0;

        // Core busy in IDLE blocks the grant until it goes empty.
        core_busy = 1;
        req0 = 1; data0 = 8'h77;
        repeat (5) begin
            @(negedge CLK);
            check("blk_ack0", ack0, 0);
        end
        core_busy = 0;
        @(negedge CLK);
        check("blk_ack0_go", ack0, 1);
        check("blk_data", tx_data, 8'h77);
        req0 = 0;
        wait_idle("blk_done", 40);

        // Reset while the core is shifting.
        req0 = 1; data0 = 8'h99;
        @(negedge CLK);
        check("rwd_ack0", ack0, 1);
        req0 = 0;
        repeat (6) @(negedge CLK);
        check("rwd_busy", busy, 1);
        check("rwd_en", tx_enable, 1);
        reset = 1;
        @(negedge CLK);
        check_reset_vals("rwd");
        reset = 0;
        repeat (15) @(negedge CLK);

        // Random traffic against the model.
        core_rand = 1;
        for (int c = 0; c < 2500; c++) begin
            @(negedge CLK);
            reset = ($urandom_range(0, 399) == 0);
            if (!req0) begin
                data0 = DATA_W'($urandom);
                if ($urandom_range(0, 2) == 0) req0 = 1;
            end else if (ack0) begin
                if ($urandom_range(0, 3) != 0) req0 = 0;
            end else if ($urandom_range(0, 19) == 0) req0 = 0;
            if (!req1) begin
                data1 = DATA_W'($urandom);
                if ($urandom_range(0, 2) == 0) req1 = 1;
            end else if (ack1) begin
                if ($urandom_range(0, 3) != 0) req1 = 0;
            end else if ($urandom_range(0, 19) == 0) req1 = 0;
        end
        core_rand = 0; core_drop = 2; core_len = 10;
        req0 = 0; req1 = 0; reset = 1;
        @(negedge CLK);
        reset = 0;
        repeat (25) @(negedge CLK);

        // Drive enough timeouts to saturate the error counter.
        core_stuck = 1;
        for (int i = 0; i < 300; i++) begin
            req0 = 1; data0 = DATA_W'($urandom);
            wait_ack("sat_ack", 5);
            req0 = 0;
            wait_idle("sat_idle", 40);
        end
        check("sat_cnt", err_cnt, 255);
        core_stuck = 0;
        repeat (2) @(negedge CLK);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
